serial_add_ctrl: RTL and testbench
==================================

Name: serial_add_ctrl

Overview:
- Bit-serial add controller: one 1-bit full-adder stage is the only adder resource, and this block sequences it LSB-first across WIDTH-bit operands.
- Latches operands on a start pulse, shifts one bit per clock through the full-adder stage, and registers the carry between bits.
- Presents the final sum/carry with a start/busy/done handshake.
- Sits between a requesting control block and the full-adder datapath; it is the team's area-minimal alternative to a ripple adder.

Parameters:
- WIDTH, 8, operand/result width in bits (legal range 1..32).
- CNT_W, $clog2(WIDTH+1), width of the internal bit counter (derived; do not override).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request pulse; sampled only in IDLE.
- a  input  WIDTH  operand A; sampled on the start-accept edge.
- b  input  WIDTH  operand B; sampled on the start-accept edge.
- cin  input  1  carry-in for bit 0; sampled on the start-accept edge.
- busy  output  1  high while an addition is in progress (RUN).
- done  output  1  one-cycle pulse; sum/cout are valid from this cycle.
- sum  output  WIDTH  registered result; holds until the next completion.
- cout  output  1  registered carry-out of bit WIDTH-1; holds like sum.

Behaviour:
- Reset (rst_n=0, asynchronous, any state): state=IDLE; busy=0, done=0, sum=0, cout=0; shift registers, carry register and counter cleared. Operation resumes on the first rising edge after rst_n deasserts.
- States: IDLE, RUN, DONE.
- IDLE -> RUN, when start=1 at edge E0:
  - a_sh<=a, b_sh<=b, carry<=cin, r_sh<=0, cnt<=0.
  - busy=1 from E0.
- RUN, each edge:
  - Full-adder inputs: a_sh[0], b_sh[0], carry.
  - r_sh<={fa_sum, r_sh[WIDTH-1:1]}; a_sh and b_sh shift right; carry<=fa_carry; cnt<=cnt+1.
  - Leave RUN on the edge where cnt==WIDTH-1 (edge E_WIDTH), i.e. exactly WIDTH shift cycles.
- RUN -> DONE at E_WIDTH:
  - sum<={fa_sum, r_sh[WIDTH-1:1]}; cout<=fa_carry.
  - busy=0, done=1.
- DONE -> IDLE at the next edge: done=0.
- Latency: start accepted at E0 -> done high in the cycle after E_WIDTH. Total WIDTH+1 cycles per operation; back-to-back throughput is one result per WIDTH+2 cycles.
- start while in RUN or DONE: ignored (no queueing, no restart). Operand changes after E0 have no effect.
- start held continuously high: a new operation is accepted in every IDLE cycle.
- sum/cout stay stable during RUN (they show the previous result) and change only on the transition into DONE.
- Arithmetic: result is the modulo-2^WIDTH sum of a+b+cin. cout is bit WIDTH of the full sum.
- WIDTH=1: RUN lasts exactly one cycle.
- Reset mid-RUN: the operation is aborted; no done pulse; outputs return to their reset values.
- busy and done are never high together. Both are registered outputs with no combinational path from inputs.

Test Plan:
- WIDTH=8, a=8'h5A, b=8'h33, cin=0, 1-cycle start -> busy high for 8 cycles; done pulses 1 cycle in the 9th cycle after the accept edge; sum=8'h8D, cout=0.
- WIDTH=8, a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1. Then a=8'hFF, b=8'hFF, cin=1 -> sum=8'hFF, cout=1. Then a=0, b=0, cin=0 -> sum=8'h00, cout=0.
- start held high throughout, with a/b changed every cycle while busy -> each result matches the operands latched at its accept edge; successive accepts are 10 cycles apart; done is never concurrent with busy.
- rst_n pulsed low for 1 ns, asynchronously, mid-RUN at cnt=4 -> busy, done, sum and cout go to 0 immediately; no done pulse; a following start with a=8'h0F, b=8'h01, cin=0 yields sum=8'h10, cout=0.
- WIDTH=1, all 8 combinations of a, b, cin -> sum/cout match the full-adder truth table; done 2 cycles after each accept.
- Between operations, sum/cout are checked every cycle during RUN -> values unchanged from the prior result until the DONE cycle.

Source files
------------

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: sequences a single full-adder stage LSB-first
// across WIDTH-bit operands, with a start/busy/done handshake.
`timescale 1ns/1ps

module serial_add_ctrl #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic [1:0]       state_dbg
);

    // Handshake: start is a request taken only in IDLE (the accept edge);
    // busy is high for exactly WIDTH cycles after acceptance, then done
    // pulses for one cycle with sum/cout already valid. No back-pressure.

    // Encoding chosen so busy and done are direct state flop bits.
    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } state_t;

    state_t           state;
    state_t           state_nxt;

    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] r_sh;
    logic [WIDTH-1:0] r_nxt;
    logic             carry;
    logic [CNT_W-1:0] cnt;

    logic             fa_sum;
    logic             fa_carry;
    logic             last_bit;

    // The single full-adder stage.
    assign fa_sum   = a_sh[0] ^ b_sh[0] ^ carry;
    assign fa_carry = (a_sh[0] & b_sh[0]) | (a_sh[0] & carry) | (b_sh[0] & carry);

    // New bit enters at the MSB so the result lands in place after WIDTH shifts.
    assign r_nxt    = (r_sh >> 1) | (WIDTH'(fa_sum) << (WIDTH - 1));
    assign last_bit = (cnt == CNT_W'(WIDTH - 1));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start)    state_nxt = S_RUN;
            S_RUN:   if (last_bit) state_nxt = S_DONE;
            S_DONE:                state_nxt = S_IDLE;
            default:               state_nxt = S_IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        busy      = state[0];
        done      = state[1];
        state_dbg = state;
    end

    // Datapath: operand shifters, carry flop, bit counter and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh  <= '0;
            b_sh  <= '0;
            r_sh  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        a_sh  <= a;
                        b_sh  <= b;
                        carry <= cin;
                        r_sh  <= '0;
                        cnt   <= '0;
                    end
                end
                S_RUN: begin
                    a_sh  <= a_sh >> 1;
                    b_sh  <= b_sh >> 1;
                    r_sh  <= r_nxt;
                    carry <= fa_carry;
                    cnt   <= cnt + 1'b1;
                    // sum/cout keep the previous result until this final bit.
                    if (last_bit) begin
                        sum  <= r_nxt;
                        cout <= fa_carry;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl at WIDTH=8 and WIDTH=1, using a
// scoreboard of expected {cout,sum} values popped on each done pulse.
`timescale 1ns/1ps

module tb_serial_add_ctrl;

    logic       clk;
    logic       rst_n;

    logic       start8;
    logic [7:0] a8;
    logic [7:0] b8;
    logic       cin8;
    logic       busy8;
    logic       done8;
    logic [7:0] sum8;
    logic       cout8;
    logic [1:0] state_dbg8;

    logic       start1;
    logic [0:0] a1;
    logic [0:0] b1;
    logic       cin1;
    logic       busy1;
    logic       done1;
    logic [0:0] sum1;
    logic       cout1;
    logic [1:0] state_dbg1;

    logic [8:0] exp8_q[$];
    logic [1:0] exp1_q[$];
    logic [8:0] prev8;
    logic [1:0] prev1;
    logic [8:0] e8;
    logic [1:0] e1;

    int n_checks;
    int n_pass;

    serial_add_ctrl #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .cin(cin8),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .state_dbg(state_dbg8)
    );

    serial_add_ctrl #(.WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .cin(cin1),
        .busy(busy1), .done(done1), .sum(sum1), .cout(cout1), .state_dbg(state_dbg1)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // scoreboard monitor, sampled on the falling edge
    always @(negedge clk) begin
        if (rst_n) begin
            check("excl8", 32'(busy8 & done8), 32'd0);
            check("excl1", 32'(busy1 & done1), 32'd0);
            if (busy8) check("hold8", 32'({cout8, sum8}), 32'(prev8));
            if (busy1) check("hold1", 32'({cout1, sum1}), 32'(prev1));
            if (done8) begin
                if (exp8_q.size() == 0) begin
                    check("spurious_done8", 32'd1, 32'd0);
                end else begin
                    e8 = exp8_q.pop_front();
                    check("result8", 32'({cout8, sum8}), 32'(e8));
                    prev8 = e8;
                end
            end
            if (done1) begin
                if (exp1_q.size() == 0) begin
                    check("spurious_done1", 32'd1, 32'd0);
                end else begin
                    e1 = exp1_q.pop_front();
                    check("result1", 32'({cout1, sum1}), 32'(e1));
                    prev1 = e1;
                end
            end
        end
    end

    // driver tasks
    task automatic run8(input logic [7:0] ta, input logic [7:0] tb, input logic tc);
        int  busy_cycles;
        bit  seen;
        @(negedge clk);
        a8 = ta; b8 = tb; cin8 = tc; start8 = 1'b1;
        exp8_q.push_back(9'(ta) + 9'(tb) + 9'(tc));
        @(posedge clk); #1;
        start8 = 1'b0;
        a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
        busy_cycles = 0;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (done8) seen = 1'b1;
            else if (busy8) busy_cycles++;
        end
        check("done_seen8", 32'(seen), 32'd1);
        check("busy_len8", 32'(busy_cycles), 32'd8);
    endtask

    task automatic run1(input logic ta, input logic tb, input logic tc);
        @(negedge clk);
        a1 = ta; b1 = tb; cin1 = tc; start1 = 1'b1;
        exp1_q.push_back(2'(ta) + 2'(tb) + 2'(tc));
        @(posedge clk); #1;
        start1 = 1'b0;
        a1 = ~a1; b1 = ~b1;
        @(negedge clk);
        check("busy_w1", 32'(busy1), 32'd1);
        check("early_done_w1", 32'(done1), 32'd0);
        @(negedge clk);
        check("done_w1", 32'(done1), 32'd1);
        check("busy_off_w1", 32'(busy1), 32'd0);
    endtask

    task automatic held_start8(input int n_ops);
        logic [7:0] ta;
        logic [7:0] tb;
        logic       tc;
        @(negedge clk);
        start8 = 1'b1;
        for (int k = 0; k < n_ops; k++) begin
            ta = 8'($urandom); tb = 8'($urandom); tc = 1'($urandom);
            a8 = ta; b8 = tb; cin8 = tc;
            exp8_q.push_back(9'(ta) + 9'(tb) + 9'(tc));
            for (int j = 1; j <= 10; j++) begin
                @(negedge clk);
                if (j == 9) check("held_done_cycle", 32'(done8), 32'd1);
                if (j == 10) check("held_idle_gap", 32'({busy8, done8}), 32'd0);
                if (j < 8) check("held_busy", 32'(busy8), 32'd1);
                if (j < 10) begin
                    a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
                end
            end
        end
        start8 = 1'b0;
    endtask

    task automatic abort_mid_run8();
        @(negedge clk);
        a8 = 8'hAA; b8 = 8'h55; cin8 = 1'b1; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #0.5;
        check("abort_busy", 32'(busy8), 32'd0);
        check("abort_done", 32'(done8), 32'd0);
        check("abort_sum", 32'(sum8), 32'd0);
        check("abort_cout", 32'(cout8), 32'd0);
        #0.5;
        rst_n = 1'b1;
        prev8 = '0;
        prev1 = '0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            check("abort_no_done", 32'({busy8, done8}), 32'd0);
        end
    endtask

    // main sequence
    initial begin
        n_checks = 0;
        n_pass   = 0;
        prev8    = '0;
        prev1    = '0;
        rst_n    = 1'b0;
        start8   = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
        start1   = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
        #12;
        check("rst_busy", 32'(busy8), 32'd0);
        check("rst_done", 32'(done8), 32'd0);
        check("rst_sum", 32'({cout8, sum8}), 32'd0);
        check("rst_w1", 32'({busy1, done1, cout1, sum1}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run8(8'h5A, 8'h33, 1'b0);
        run8(8'hFF, 8'h01, 1'b0);
        run8(8'hFF, 8'hFF, 1'b1);
        run8(8'h00, 8'h00, 1'b0);
        for (int i = 0; i < 6; i++) begin
            run8(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
        end

        held_start8(4);
        repeat (2) @(negedge clk);

        abort_mid_run8();
        run8(8'h0F, 8'h01, 1'b0);

        for (int c = 0; c < 8; c++) begin
            run1(c[2], c[1], c[0]);
        end

        repeat (3) @(negedge clk);
        check("queue8_empty", 32'(exp8_q.size()), 32'd0);
        check("queue1_empty", 32'(exp1_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
